// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memory: request, write strobe, address select and ack.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the course CPU datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the PC, IR,
// register-file, ALU, memory and immediate-extender controls. Memory accesses
// use a req/ack handshake with a bounded wait; on timeout the request drops
// for one cycle, bus_err pulses and the access is retried.
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds a retired-instruction
// counter output (retired[31:0]).
module multicycle_ctrl #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_ctrl_if.master        mem,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic                     zero,
  output logic                     pc_we,
  output logic [1:0]               pc_src,
  output logic                     ir_we,
  output logic                     mdr_we,
  output logic                     reg_we,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     alu_src_b,
  output logic [2:0]               alu_ctl,
  output logic [1:0]               ext_op,
  output logic [2:0]               state,
  output logic                     illegal,
  output logic                     bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]              retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [5:0]       op_q, fn_q;
  logic             holdoff_q, holdoff_d;
  logic             reqActive;
  logic             ackSeen;
  logic             timeout;
  logic             memReq, memWe, addrSel;

  function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: isLegal = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                          (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW:
                isLegal = 1'b1;
      default:  isLegal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] decodeAlu(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SUB:  decodeAlu = ALU_SUB;
          FN_AND:  decodeAlu = ALU_AND;
          FN_OR:   decodeAlu = ALU_OR;
          FN_SLT:  decodeAlu = ALU_SLT;
          default: decodeAlu = ALU_ADD;
        endcase
      end
      OP_BEQ:          decodeAlu = ALU_SUB;
      OP_ANDI:         decodeAlu = ALU_AND;
      OP_ORI, OP_LUI:  decodeAlu = ALU_OR;
      default:         decodeAlu = ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] decodeExt(input logic [5:0] op);
    case (op)
      OP_ANDI, OP_ORI: decodeExt = 2'b01;
      OP_LUI:          decodeExt = 2'b10;
      default:         decodeExt = 2'b00;
    endcase
  endfunction

  // Wait-counter and request hold-off: count unacknowledged request cycles,
  // and drop the request for one cycle after a timeout before retrying.
  always_comb begin
    reqActive = ((state_q == S_FETCH) || (state_q == S_MEM)) && !holdoff_q;
    ackSeen   = reqActive && mem.mem_ack;
    timeout   = reqActive && !mem.mem_ack && (waitCnt_q == TIMEOUT_VAL);
    waitCnt_d = '0;
    holdoff_d = 1'b0;
    if (timeout) begin
      holdoff_d = 1'b1;
    end else if (reqActive && !mem.mem_ack) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // Next-state and control outputs; everything idles low unless the
  // current state names it, and ALU/extender modes stay valid EXEC..WB.
  always_comb begin
    state_d    = state_q;
    memReq     = 1'b0;
    memWe      = 1'b0;
    addrSel    = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_ctl    = ALU_ADD;
    ext_op     = 2'b00;
    illegal    = 1'b0;
    bus_err    = 1'b0;

    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      alu_ctl = decodeAlu(op_q, fn_q);
      ext_op  = decodeExt(op_q);
    end

    case (state_q)
      S_FETCH: begin
        memReq  = !holdoff_q;
        bus_err = timeout;
        if (ackSeen) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!isLegal(opcode, funct)) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (opcode == OP_J) begin
          pc_we   = 1'b1;
          pc_src  = 2'd2;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_BEQ: begin
            pc_we   = zero;
            pc_src  = 2'd1;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_RTYPE: begin
            state_d = S_WB;
          end
          default: begin
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
        endcase
      end
      S_MEM: begin
        memReq  = !holdoff_q;
        addrSel = 1'b1;
        memWe   = !holdoff_q && (op_q == OP_SW);
        bus_err = timeout;
        if (ackSeen) begin
          if (op_q == OP_SW) begin
            state_d = S_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, wait counter and instruction fields; reset also holds the
  // request low for the first cycle so an in-flight access is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
      op_q      <= '0;
      fn_q      <= '0;
      holdoff_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      holdoff_q <= holdoff_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  assign mem.mem_req  = memReq;
  assign mem.mem_we   = memWe;
  assign mem.addr_sel = addrSel;
  assign state        = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired_q;
  logic        retireEvt;

  // An instruction retires as it leaves its final state: j in DECODE,
  // beq in EXEC, sw on its memory ack, everything else in WB.
  always_comb begin
    retireEvt = ((state_q == S_DECODE) && isLegal(opcode, funct) && (opcode == OP_J)) ||
                ((state_q == S_EXEC) && (op_q == OP_BEQ)) ||
                ((state_q == S_MEM) && ackSeen && (op_q == OP_SW)) ||
                (state_q == S_WB);
  end

  // Free-running retired-instruction count, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retireEvt) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class
// through the FSM with hand-computed expected control values per cycle.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mdr_we;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_b;
  logic [2:0] alu_ctl;
  logic [1:0] ext_op;
  logic [2:0] state;
  logic       illegal;
  logic       bus_err;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired;
`endif

  int checks;
  int errors;
  logic [31:0] obs;
  logic [31:0] expv;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .ACK_TIMEOUT(15),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem(bus),
    .opcode(opcode),
    .funct(funct),
    .zero(zero),
    .pc_we(pc_we),
    .pc_src(pc_src),
    .ir_we(ir_we),
    .mdr_we(mdr_we),
    .reg_we(reg_we),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b),
    .alu_ctl(alu_ctl),
    .ext_op(ext_op),
    .state(state),
    .illegal(illegal),
    .bus_err(bus_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .retired(retired)
`endif
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in FETCH with a same-cycle ack; ends in DECODE
  task automatic fetchWith(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct = fn;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    obs  = 32'({state, bus.mem_req, bus.mem_we, bus.addr_sel, pc_we, pc_src, ir_we,
                mdr_we, reg_we, illegal, bus_err, alu_ctl, ext_op});
    expv = 32'({3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                3'b010, 2'b00});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, expv);
    end
    rst = 1'b0;
    tick();
    #1;
    obs  = 32'({state, bus.mem_req, bus.addr_sel});
    expv = 32'({3'd0, 1'b1, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_add();
    opcode = 6'h00;
    funct = 6'h20;
    bus.mem_ack = 1'b1;
    #1;
    obs  = 32'({state, bus.mem_req, bus.addr_sel, ir_we, pc_we, pc_src});
    expv = 32'({3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL add_fetch: got %h expected %h", obs, expv);
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    obs  = 32'({state, illegal, pc_we, bus.mem_req});
    expv = 32'({3'd1, 1'b0, 1'b0, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL add_decode: got %h expected %h", obs, expv);
    end
    tick();
    #1;
    obs  = 32'({state, alu_ctl, alu_src_b, ext_op});
    expv = 32'({3'd2, 3'b010, 1'b0, 2'b00});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL add_exec: got %h expected %h", obs, expv);
    end
    tick();
    #1;
    obs  = 32'({state, reg_we, reg_dst, mem_to_reg, alu_ctl});
    expv = 32'({3'd4, 1'b1, 1'b1, 1'b0, 3'b010});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL add_wb: got %h expected %h", obs, expv);
    end
    tick();
    #1;
    obs  = 32'({state, reg_we, bus.mem_req});
    expv = 32'({3'd0, 1'b0, 1'b1});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL add_return: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops [3];
    logic [1:0] extExp [3];
    logic [2:0] aluExp [3];
    ops[0] = 6'h0D; extExp[0] = 2'b01; aluExp[0] = 3'b001;
    ops[1] = 6'h0F; extExp[1] = 2'b10; aluExp[1] = 3'b001;
    ops[2] = 6'h08; extExp[2] = 2'b00; aluExp[2] = 3'b010;
    for (int i = 0; i < 3; i++) begin
      fetchWith(ops[i], 6'h00);
      tick();
      #1;
      obs  = 32'({state, ext_op, alu_ctl, alu_src_b});
      expv = 32'({3'd2, extExp[i], aluExp[i], 1'b1});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL imm_exec_op%h: got %h expected %h", ops[i], obs, expv);
      end
      tick();
      #1;
      obs  = 32'({state, reg_we, reg_dst, mem_to_reg, ext_op, alu_ctl});
      expv = 32'({3'd4, 1'b1, 1'b0, 1'b0, extExp[i], aluExp[i]});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL imm_wb_op%h: got %h expected %h", ops[i], obs, expv);
      end
      tick();
    end
  endtask

  task automatic test_lw_delay();
    fetchWith(6'h23, 6'h00);
    tick();
    #1;
    obs  = 32'({state, alu_ctl, alu_src_b, ext_op});
    expv = 32'({3'd2, 3'b010, 1'b1, 2'b00});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL lw_exec: got %h expected %h", obs, expv);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.mem_ack = (k == 3);
      #1;
      obs  = 32'({state, bus.mem_req, bus.addr_sel, bus.mem_we, mdr_we, bus_err});
      expv = 32'({3'd3, 1'b1, 1'b1, 1'b0, (k == 3), 1'b0});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL lw_mem_wait%0d: got %h expected %h", k, obs, expv);
      end
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    obs  = 32'({state, reg_we, reg_dst, mem_to_reg, bus.mem_req, mdr_we});
    expv = 32'({3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL lw_wb: got %h expected %h", obs, expv);
    end
    tick();
  endtask

  task automatic test_sw();
    fetchWith(6'h2B, 6'h00);
    tick();
    tick();
    bus.mem_ack = 1'b1;
    #1;
    obs  = 32'({state, bus.mem_req, bus.addr_sel, bus.mem_we, mdr_we, alu_ctl});
    expv = 32'({3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL sw_mem: got %h expected %h", obs, expv);
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    obs  = 32'({state, reg_we, bus.mem_we});
    expv = 32'({3'd0, 1'b0, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL sw_return: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      fetchWith(6'h04, 6'h00);
      zero = z[0];
      tick();
      #1;
      obs  = 32'({state, alu_ctl, alu_src_b, pc_we, pc_src});
      expv = 32'({3'd2, 3'b110, 1'b0, z[0], 2'd1});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL beq_exec_zero%0d: got %h expected %h", z, obs, expv);
      end
      tick();
      zero = 1'b0;
      #1;
      obs  = 32'({state, pc_we});
      expv = 32'({3'd0, 1'b0});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL beq_return_zero%0d: got %h expected %h", z, obs, expv);
      end
    end
  endtask

  task automatic test_j();
    fetchWith(6'h02, 6'h00);
    obs  = 32'({state, pc_we, pc_src, illegal});
    expv = 32'({3'd1, 1'b1, 2'd2, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL j_decode: got %h expected %h", obs, expv);
    end
    tick();
    #1;
    obs  = 32'({state, pc_we, bus.mem_req});
    expv = 32'({3'd0, 1'b0, 1'b1});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL j_return: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_illegal();
    logic [11:0] vec [2];
    vec[0] = {6'h3F, 6'h00};
    vec[1] = {6'h00, 6'h21};
    for (int i = 0; i < 2; i++) begin
      fetchWith(vec[i][11:6], vec[i][5:0]);
      obs  = 32'({state, illegal, pc_we});
      expv = 32'({3'd1, 1'b1, 1'b0});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL illegal_decode%0d: got %h expected %h", i, obs, expv);
      end
      tick();
      #1;
      obs  = 32'({state, illegal});
      expv = 32'({3'd0, 1'b0});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL illegal_return%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_timeout();
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      #1;
      obs  = 32'({state, bus.mem_req, pc_we, ir_we, bus_err});
      expv = 32'({3'd0, 1'b1, 1'b0, 1'b0, (k == 15)});
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL timeout_wait%0d: got %h expected %h", k, obs, expv);
      end
    end
    tick();
    #1;
    obs  = 32'({state, bus.mem_req, bus_err, pc_we});
    expv = 32'({3'd0, 1'b0, 1'b0, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL timeout_gap: got %h expected %h", obs, expv);
    end
    tick();
    opcode = 6'h02;
    funct = 6'h00;
    #1;
    obs  = 32'({state, bus.mem_req});
    expv = 32'({3'd0, 1'b1});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL timeout_retry: got %h expected %h", obs, expv);
    end
    for (int k = 1; k < 16; k++) begin
      tick();
    end
    bus.mem_ack = 1'b1;
    #1;
    obs  = 32'({bus_err, ir_we, pc_we});
    expv = 32'({1'b0, 1'b1, 1'b1});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL timeout_ack_wins: got %h expected %h", obs, expv);
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    obs  = 32'({state, pc_src});
    expv = 32'({3'd1, 2'd2});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL timeout_after_ack: got %h expected %h", obs, expv);
    end
    tick();
  endtask

  task automatic test_reset_mid_mem();
    fetchWith(6'h23, 6'h00);
    tick();
    tick();
    #1;
    obs  = 32'({state, bus.mem_req});
    expv = 32'({3'd3, 1'b1});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL midmem_before: got %h expected %h", obs, expv);
    end
    rst = 1'b1;
    tick();
    #1;
    obs  = 32'({state, bus.mem_req, bus.addr_sel, mdr_we});
    expv = 32'({3'd0, 1'b0, 1'b0, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL midmem_reset: got %h expected %h", obs, expv);
    end
    rst = 1'b0;
    tick();
    #1;
    obs  = 32'({state, bus.mem_req, bus.addr_sel});
    expv = 32'({3'd0, 1'b1, 1'b0});
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL midmem_restart: got %h expected %h", obs, expv);
    end
  endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (retired !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset: got %0d expected 0", retired);
    end
    fetchWith(6'h02, 6'h00);
    tick();
    fetchWith(6'h2B, 6'h00);
    tick();
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    fetchWith(6'h3F, 6'h00);
    tick();
    fetchWith(6'h00, 6'h20);
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (retired !== 32'd3) begin
      errors++;
      $display("[TB] FAIL perf_count: got %0d expected 3", retired);
    end
  endtask
`endif

  // Scenario sequence and final summary
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    bus.mem_ack = 1'b0;
    test_reset();
    test_add();
    test_imm();
    test_lw_delay();
    test_sw();
    test_beq();
    test_j();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
`ifdef MULTICYCLE_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
